// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: VGA timing bundle driven by the generator and consumed by draw logic.
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
);
  logic             Pix_Ena_Out;
  logic             Sync_Horiz_Out;
  logic             Sync_Vert_Out;
  logic             Disp_Ena_Out;
  logic [CNT_W-1:0] Val_Col_Out;
  logic [CNT_W-1:0] Val_Row_Out;
  logic             Line_Start_Out;
  logic             Frame_Start_Out;
  modport master (
    output Pix_Ena_Out, Sync_Horiz_Out, Sync_Vert_Out, Disp_Ena_Out,
    output Val_Col_Out, Val_Row_Out, Line_Start_Out, Frame_Start_Out
  );
  modport slave (
    input Pix_Ena_Out, Sync_Horiz_Out, Sync_Vert_Out, Disp_Ena_Out,
    input Val_Col_Out, Val_Row_Out, Line_Start_Out, Frame_Start_Out
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing with integrated pixel-rate divider and tick-aligned delay pipe.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 4,
  parameter int PIPE_DLY = 0,
  parameter int CNT_W    = 10
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_N_In,
  vga_timing_gen_if.master o_vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  if (CLK_DIV < 1 || PIPE_DLY < 0 || PIPE_DLY > 7 ||
      H_TOTAL - 1 >= (1 << CNT_W) || V_TOTAL - 1 >= (1 << CNT_W) ||
      H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_err
    $error("vga_timing_gen: illegal parameter set");
  end
  logic [DIV_W-1:0] r_div;
  logic             r_pix_ena;
  logic [CNT_W-1:0] r_h, r_v, r_col, r_row;
  logic             w_tick, w_act;
  logic [4:0]       w_dec;
  // stage bits {hsync active, vsync active, disp enable, line start, frame start}
  logic [4:0]       r_pipe [0:PIPE_DLY];
  assign w_tick = r_div == DIV_LAST;
  assign w_act  = r_h < H_ACT && r_v < V_ACT;
  assign w_dec  = {r_h >= HS_BEG && r_h <= HS_END, r_v >= VS_BEG && r_v <= VS_END,
                   w_act, r_h == '0, r_h == '0 && r_v == '0};
  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_div     <= '0;
      r_pix_ena <= 1'b0;
      r_h       <= '0;
      r_v       <= '0;
      r_col     <= '0;
      r_row     <= '0;
      for (int i = 0; i <= PIPE_DLY; i++) r_pipe[i] <= '0;
    end else begin
      r_div     <= w_tick ? '0 : r_div + DIV_W'(1);
      r_pix_ena <= w_tick;
      if (w_tick) begin
        r_h   <= (r_h == H_LAST) ? '0 : r_h + CNT_W'(1);
        if (r_h == H_LAST) r_v <= (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
        r_col <= w_act ? r_h : '0;
        r_row <= w_act ? r_v : '0;
        r_pipe[0] <= w_dec;
        for (int i = 1; i <= PIPE_DLY; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
  end
  // strobes are held in the pipe for a whole tick period but shown only on the tick clock
  assign o_vga.Pix_Ena_Out     = r_pix_ena;
  assign o_vga.Sync_Horiz_Out  = (H_POL != 0) ? r_pipe[PIPE_DLY][4] : ~r_pipe[PIPE_DLY][4];
  assign o_vga.Sync_Vert_Out   = (V_POL != 0) ? r_pipe[PIPE_DLY][3] : ~r_pipe[PIPE_DLY][3];
  assign o_vga.Disp_Ena_Out    = r_pipe[PIPE_DLY][2];
  assign o_vga.Line_Start_Out  = r_pipe[PIPE_DLY][1] & r_pix_ena;
  assign o_vga.Frame_Start_Out = r_pipe[PIPE_DLY][0] & r_pix_ena;
  assign o_vga.Val_Col_Out     = r_col;
  assign o_vga.Val_Row_Out     = r_row;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three configurations checked every clock against an arithmetic pixel-stream model.
module tb_vga_timing_gen;
  typedef struct packed {int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, dv, dl;} cfg_t;
  typedef struct packed {logic pe, hs, vs, de, ls, fs; logic [9:0] col, row;} o_t;
  localparam cfg_t CA = '{ha:8, hf:2, hs:2, hb:2, va:4, vf:1, vs:1, vb:1, hp:1, vp:1, dv:1, dl:0};
  localparam cfg_t CB = '{ha:8, hf:2, hs:2, hb:2, va:4, vf:1, vs:1, vb:1, hp:0, vp:0, dv:3, dl:2};
  localparam cfg_t CC = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hp:0, vp:0, dv:4, dl:0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   k;
  int   tests = 0;
  int   fails = 0;
  bit   chk = 1'b0;
  vga_timing_gen_if #(.CNT_W(10)) ia ();
  vga_timing_gen_if #(.CNT_W(10)) ib ();
  vga_timing_gen_if #(.CNT_W(10)) ic ();
  vga_timing_gen #(.H_ACTIVE(CA.ha), .H_FP(CA.hf), .H_SYNC(CA.hs), .H_BP(CA.hb),
    .V_ACTIVE(CA.va), .V_FP(CA.vf), .V_SYNC(CA.vs), .V_BP(CA.vb), .H_POL(CA.hp), .V_POL(CA.vp),
    .CLK_DIV(CA.dv), .PIPE_DLY(CA.dl), .CNT_W(10)) ua (.Master_Clock_In(clk), .Reset_N_In(rst_n), .o_vga(ia));
  vga_timing_gen #(.H_ACTIVE(CB.ha), .H_FP(CB.hf), .H_SYNC(CB.hs), .H_BP(CB.hb),
    .V_ACTIVE(CB.va), .V_FP(CB.vf), .V_SYNC(CB.vs), .V_BP(CB.vb), .H_POL(CB.hp), .V_POL(CB.vp),
    .CLK_DIV(CB.dv), .PIPE_DLY(CB.dl), .CNT_W(10)) ub (.Master_Clock_In(clk), .Reset_N_In(rst_n), .o_vga(ib));
  vga_timing_gen #(.H_ACTIVE(CC.ha), .H_FP(CC.hf), .H_SYNC(CC.hs), .H_BP(CC.hb),
    .V_ACTIVE(CC.va), .V_FP(CC.vf), .V_SYNC(CC.vs), .V_BP(CC.vb), .H_POL(CC.hp), .V_POL(CC.vp),
    .CLK_DIV(CC.dv), .PIPE_DLY(CC.dl), .CNT_W(10)) uc (.Master_Clock_In(clk), .Reset_N_In(rst_n), .o_vga(ic));
  o_t act_a, act_b, act_c;
  assign act_a = '{pe:ia.Pix_Ena_Out, hs:ia.Sync_Horiz_Out, vs:ia.Sync_Vert_Out, de:ia.Disp_Ena_Out,
                   ls:ia.Line_Start_Out, fs:ia.Frame_Start_Out, col:ia.Val_Col_Out, row:ia.Val_Row_Out};
  assign act_b = '{pe:ib.Pix_Ena_Out, hs:ib.Sync_Horiz_Out, vs:ib.Sync_Vert_Out, de:ib.Disp_Ena_Out,
                   ls:ib.Line_Start_Out, fs:ib.Frame_Start_Out, col:ib.Val_Col_Out, row:ib.Val_Row_Out};
  assign act_c = '{pe:ic.Pix_Ena_Out, hs:ic.Sync_Horiz_Out, vs:ic.Sync_Vert_Out, de:ic.Disp_Ena_Out,
                   ls:ic.Line_Start_Out, fs:ic.Frame_Start_Out, col:ic.Val_Col_Out, row:ic.Val_Row_Out};
  always #5 clk = ~clk;
  // k = master clocks seen since reset release
  always @(posedge clk or negedge rst_n) k <= !rst_n ? 0 : k + 1;
  // After kk clocks, kk/dv ticks have occurred; the last one presented pixel number kk/dv-1 of the raster stream.
  function automatic o_t model(cfg_t c, int kk);
    int ht, vt, p, q, h, v;
    bit hact, vact;
    o_t o;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    o = '0;
    o.hs = !c.hp[0];
    o.vs = !c.vp[0];
    if (kk == 0) return o;
    o.pe = (kk % c.dv) == 0;
    if (kk < c.dv) return o;
    p = kk / c.dv - 1;
    h = p % ht;
    v = (p / ht) % vt;
    if (h < c.ha && v < c.va) begin
      o.col = 10'(h);
      o.row = 10'(v);
    end
    q = p - c.dl;
    if (q < 0) return o;
    h = q % ht;
    v = (q / ht) % vt;
    hact = h >= c.ha + c.hf && h < c.ha + c.hf + c.hs;
    vact = v >= c.va + c.vf && v < c.va + c.vf + c.vs;
    o.hs = hact ? c.hp[0] : !c.hp[0];
    o.vs = vact ? c.vp[0] : !c.vp[0];
    o.de = h < c.ha && v < c.va;
    o.ls = o.pe && h == 0;
    o.fs = o.pe && h == 0 && v == 0;
    return o;
  endfunction
  task automatic cmp(string n, o_t a, o_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s k=%0d got pe%b hs%b vs%b de%b ls%b fs%b col%0d row%0d, expected pe%b hs%b vs%b de%b ls%b fs%b col%0d row%0d",
               n, k, a.pe, a.hs, a.vs, a.de, a.ls, a.fs, a.col, a.row, e.pe, e.hs, e.vs, e.de, e.ls, e.fs, e.col, e.row);
    end
  endtask
  task automatic lit(string n, int a, int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s k=%0d got %0d expected %0d", n, k, a, e);
    end
  endtask
  task automatic wait_k(int x);
    int g = 0;
    while (k != x && g < 200000) begin
      @(negedge clk);
      g++;
    end
    if (k != x) begin
      tests++;
      fails++;
      $display("FAIL wait_k got %0d expected %0d", k, x);
    end
  endtask
  always @(negedge clk) if (chk) begin
    cmp("cfgA", act_a, model(CA, k));
    cmp("cfgB", act_b, model(CB, k));
    cmp("cfgC", act_c, model(CC, k));
  end
  initial begin
    chk = 1'b1;
    repeat (3) @(negedge clk);
    lit("rst_c_hs", int'(ic.Sync_Horiz_Out), 1);
    lit("rst_c_vs", int'(ic.Sync_Vert_Out), 1);
    lit("rst_a_hs", int'(ia.Sync_Horiz_Out), 0);
    lit("rst_c_de", int'(ic.Disp_Ena_Out), 0);
    #2 rst_n = 1'b1;
    wait_k(3);  lit("c_pe_k3", int'(ic.Pix_Ena_Out), 0);
    wait_k(4);  lit("c_pe_k4", int'(ic.Pix_Ena_Out), 1);
    lit("c_fs_k4", int'(ic.Frame_Start_Out), 1);
    lit("c_de_k4", int'(ic.Disp_Ena_Out), 1);
    lit("c_col_k4", int'(ic.Val_Col_Out), 0);
    wait_k(5);  lit("c_fs_k5", int'(ic.Frame_Start_Out), 0);
    lit("a_col_k5", int'(ia.Val_Col_Out), 4);
    wait_k(9);  lit("b_de_k9", int'(ib.Disp_Ena_Out), 1);
    lit("b_col_k9", int'(ib.Val_Col_Out), 2);
    wait_k(10); lit("a_hs_h9", int'(ia.Sync_Horiz_Out), 0);
    wait_k(11); lit("a_hs_h10", int'(ia.Sync_Horiz_Out), 1);
    wait_k(13); lit("a_hs_h12", int'(ia.Sync_Horiz_Out), 0);
    wait_k(70); lit("a_vs_v4", int'(ia.Sync_Vert_Out), 0);
    wait_k(71); lit("a_vs_v5", int'(ia.Sync_Vert_Out), 1);
    wait_k(99); lit("a_fs_frame2", int'(ia.Frame_Start_Out), 1);
    wait_k(2624); lit("c_hs_h655", int'(ic.Sync_Horiz_Out), 1);
    wait_k(2628); lit("c_hs_h656", int'(ic.Sync_Horiz_Out), 0);
    wait_k(3204); lit("c_ls_line1", int'(ic.Line_Start_Out), 1);
    lit("c_row_line1", int'(ic.Val_Row_Out), 1);
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(30, 2500)) @(negedge clk);
      #2 rst_n = 1'b0;
      #2;
      cmp("async_a", act_a, model(CA, 0));
      cmp("async_b", act_b, model(CB, 0));
      cmp("async_c", act_c, model(CC, 0));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #2 rst_n = 1'b1;
    end
    wait_k(1); lit("a_fs_restart", int'(ia.Frame_Start_Out), 1);
    wait_k(3); lit("b_de_restart", int'(ib.Disp_Ena_Out), 0);
    wait_k(4); lit("c_fs_restart", int'(ic.Frame_Start_Out), 1);
    repeat (300) @(negedge clk);
    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; successor to the fixed 640x480 VGA_Control plus separate Clock_Div.
- Integrates the pixel-rate divider, supports any resolution, porch widths and sync polarity, and emits frame/line start strobes.
- Delays sync and enable by a configurable number of pixels so they stay aligned with pipelined draw logic.
- Sits between the board clock and the draw block; runs on the master clock with a pixel enable instead of a derived clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- CLK_DIV, 4, master clocks per pixel; must be >=1
- PIPE_DLY, 0, extra pixel ticks of delay on sync, enable and strobes; range 0..7
- CNT_W, 10, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- Master_Clock_In  in  1  master clock; all logic on rising edge
- Reset_N_In  in  1  asynchronous, active-low reset
- Pix_Ena_Out  out  1  one-clock pixel tick, every CLK_DIV clocks
- Sync_Horiz_Out  out  1  horizontal sync, polarity H_POL
- Sync_Vert_Out  out  1  vertical sync, polarity V_POL
- Disp_Ena_Out  out  1  high while the presented pixel is in the active area
- Val_Col_Out  out  CNT_W  presented column; 0 outside the active area
- Val_Row_Out  out  CNT_W  presented row; 0 outside the active area
- Line_Start_Out  out  1  one-clock strobe when column 0 is presented
- Frame_Start_Out  out  1  one-clock strobe when pixel (0,0) is presented

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise for the vertical parameters.
- Divider: counter runs 0..CLK_DIV-1 and wraps. Pix_Ena_Out is registered and high for the single clock after the counter reaches CLK_DIV-1. With CLK_DIV=1, Pix_Ena_Out is constantly high after reset.
- Counters h and v hold the next pixel to present.
- On each tick:
  - outputs register the decode of (h,v);
  - h increments, wrapping from H_TOTAL-1 to 0;
  - on an h wrap, v increments, wrapping from V_TOTAL-1 to 0.
- Decode, in line order active, FP, sync, BP:
  - active = h<H_ACTIVE and v<V_ACTIVE;
  - hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1];
  - vsync active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Val_Col_Out/Val_Row_Out equal h/v when active, else 0. They update only on ticks and are never delayed by PIPE_DLY.
- Line_Start_Out and Frame_Start_Out are high for exactly one master clock (the clock of the tick update), regardless of CLK_DIV.
- PIPE_DLY>0: sync, Disp_Ena and both strobes pass through a PIPE_DLY-stage shift register that advances only on ticks.
  - Reset fills every stage with deasserted values.
  - Delayed strobes are one master clock wide, aligned to the tick.
  - PIPE_DLY=0 bypasses the register entirely.
- Reset asynchronously clears everything:
  - divider, h, v, Col, Row = 0;
  - Pix_Ena, Disp_Ena, strobes = 0;
  - Sync_Horiz_Out = ~H_POL, Sync_Vert_Out = ~V_POL (deasserted).
- After reset release, the first tick presents (0,0): Disp_Ena_Out=1, Frame_Start_Out=1, Line_Start_Out=1.
- Reset mid-frame aborts the frame immediately; there is no partial-frame recovery, and timing restarts at (0,0).
- Pixel latency: the decode appears 1 clock after the tick condition; sync/enable/strobes add PIPE_DLY ticks on top.
- Parameter checks: a simulation-time check fails if CLK_DIV<1, if CNT_W is too narrow for H_TOTAL-1 or V_TOTAL-1, or if any porch/sync value is 0.

Test Plan:
- Reset: hold Reset_N_In low with defaults -> all outputs at their reset values, both syncs =1. Release -> first Pix_Ena_Out 4 clocks later; Frame_Start_Out=1, Col=0, Row=0, Disp_Ena_Out=1.
- Default horizontal timing: Disp_Ena_Out high for 640 consecutive ticks per line, hsync low for ticks 656..751, line period 800 ticks = 3200 clocks.
- Default frame: vsync low on lines 490-491, Disp_Ena_Out never high on rows >=480, Frame_Start_Out period 1,680,000 clocks.
- Small config, H=8/2/2/2, V=4/1/1/1, CLK_DIV=1, H_POL=V_POL=1: hsync high at h=10,11; vsync high on line 5; frame = 14x7 = 98 clocks; Col/Row sequence checked exhaustively.
- PIPE_DLY=2 on the small config: Disp_Ena_Out rises 2 ticks after Col=0 is presented; the Col/Row timing is unchanged versus PIPE_DLY=0.
- Reset asserted at row 200, col 300 -> outputs return to reset values asynchronously. After release, the next Frame_Start_Out occurs on the first tick and no stale delayed sync appears.
